// File: rtl/nios2_sysid_pkg.sv
// rtl/nios2_sysid_pkg.sv - shared state type and constants for the system-ID checker
package nios2_sysid_pkg;

  localparam int WORD_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/nios2_sysid_rd_timer.sv
// rtl/nios2_sysid_rd_timer.sv - 16-bit cycle counter shared by the stall-timeout and read-latency paths
module nios2_sysid_rd_timer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_inc,
  input  logic [15:0] i_limit,
  output logic        o_expire
);

  logic [15:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expire = (r_count == i_limit);

endmodule

// File: rtl/nios2_sysid_checker.sv
// rtl/nios2_sysid_checker.sv - Avalon-MM master reading and checking the system-ID words
// NIOS2_SYSID_CHECK_AUTOSTART_EN: launch one check automatically after every reset release.
module nios2_sysid_checker
  import nios2_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1588802763,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [WORD_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_match,
  output logic              ts_match,
  output logic              timeout_err,
  output logic [WORD_W-1:0] id_value,
  output logic [WORD_W-1:0] ts_value
);

  localparam logic [15:0] LAT_LIMIT = 16'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_next;
  logic r_read, r_addr, r_busy, r_done, r_id_match, r_ts_match, r_timeout;
  logic [WORD_W-1:0] r_id_value, r_ts_value;
  logic w_start, w_acc, w_expire, w_load, w_inc, w_in_lat;
  logic w_cap_id, w_cap_ts, w_timeout;
  logic [15:0] w_limit;

`ifdef NIOS2_SYSID_CHECK_AUTOSTART_EN
  logic r_auto;
  always_ff @(posedge clock) begin
    if (reset) r_auto <= 1'b1;
    else       r_auto <= 1'b0;
  end
  assign w_start = start || r_auto;
`else
  assign w_start = start;
`endif

  assign w_acc    = avm_read && !avm_waitrequest;
  assign w_in_lat = (r_state == ST_LAT_ID) || (r_state == ST_LAT_TS);
  assign w_limit  = w_in_lat ? LAT_LIMIT : TO_LIMIT;
  assign w_inc    = w_in_lat || avm_waitrequest;
  // Counter restarts on every entry to a read or latency phase.
  assign w_load   = (w_next != r_state) &&
                    ((w_next == ST_RD_ID) || (w_next == ST_LAT_ID) ||
                     (w_next == ST_RD_TS) || (w_next == ST_LAT_TS));

  nios2_sysid_rd_timer u_timer (
    .i_clk   (clock),
    .i_reset (reset),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_limit (w_limit),
    .o_expire(w_expire)
  );

  always_comb begin
    w_next    = r_state;
    w_cap_id  = 1'b0;
    w_cap_ts  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_next = ST_RD_ID;
      ST_RD_ID: begin
        if (w_acc) begin
          if (READ_LATENCY == 0) begin
            w_cap_id = 1'b1;
            w_next   = ST_RD_TS;
          end else begin
            w_next = ST_LAT_ID;
          end
        end else if (avm_waitrequest && w_expire) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_LAT_ID: if (w_expire) begin
        w_cap_id = 1'b1;
        w_next   = ST_RD_TS;
      end
      ST_RD_TS: begin
        if (w_acc) begin
          if (READ_LATENCY == 0) begin
            w_cap_ts = 1'b1;
            w_next   = ST_DONE;
          end else begin
            w_next = ST_LAT_TS;
          end
        end else if (avm_waitrequest && w_expire) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_LAT_TS: if (w_expire) begin
        w_cap_ts = 1'b1;
        w_next   = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_read     <= 1'b0;
      r_addr     <= SYSID_ADDR_ID;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_state <= w_next;
      r_read  <= (w_next == ST_RD_ID) || (w_next == ST_RD_TS);
      r_addr  <= ((w_next == ST_RD_TS) || (w_next == ST_LAT_TS)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      r_busy  <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done  <= (w_next == ST_DONE);
      if ((r_state == ST_IDLE) && w_start) begin
        r_id_match <= 1'b0;
        r_ts_match <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_cap_id) begin
        r_id_value <= avm_readdata;
        r_id_match <= (avm_readdata == EXPECTED_ID);
      end
      if (w_cap_ts) begin
        r_ts_value <= avm_readdata;
        r_ts_match <= (avm_readdata == EXPECTED_TS);
      end
      if (w_timeout) r_timeout <= 1'b1;
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout_err = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
